// File: rtl/bfp_expand.sv
// Block-floating-point expander: one exponent header per block of BLOCK_LEN
// narrow mantissas, each emitted as a saturated wide fixed-point sample.
module bfp_expand #(
    parameter int N_BITS_IN  = 4,
    parameter int BIN_PT_IN  = 3,
    parameter int N_BITS_OUT = 8,
    parameter int BIN_PT_OUT = 7,
    parameter int BLOCK_LEN  = 16,
    parameter int EXP_BITS   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_BITS_IN-1:0]  s_data,
    input  logic                  s_hdr,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [N_BITS_OUT-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  m_sat,
    output logic                  err
);

    localparam int DELTA  = BIN_PT_OUT - BIN_PT_IN;
    localparam int FULL_W = N_BITS_IN + (1 << EXP_BITS) - 1 + DELTA;
    localparam int CMP_W  = ((FULL_W > N_BITS_OUT) ? FULL_W : N_BITS_OUT) + 1;
    localparam int SH_W   = $clog2(FULL_W) + 1;
    localparam int CNT_W  = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);
    localparam logic signed [CMP_W-1:0] OUT_MAX = CMP_W'((64'sd1 <<< (N_BITS_OUT - 1)) - 64'sd1);
    localparam logic signed [CMP_W-1:0] OUT_MIN = -OUT_MAX - CMP_W'(1);

    generate
        if (BIN_PT_OUT < BIN_PT_IN) begin : g_bad_bin_pt
            $error("bfp_expand: BIN_PT_OUT must be >= BIN_PT_IN");
        end
        if (BLOCK_LEN < 1) begin : g_bad_block_len
            $error("bfp_expand: BLOCK_LEN must be >= 1");
        end
        if (EXP_BITS > N_BITS_IN) begin : g_bad_exp_bits
            $error("bfp_expand: EXP_BITS must be <= N_BITS_IN");
        end
    endgenerate

    typedef enum logic {HDR, DATA} state_t;

    state_t                state, state_nxt;
    logic [EXP_BITS-1:0]   blk_exp, blk_exp_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic                  err_nxt;
    logic                  load;
    logic                  accept;

    logic signed [N_BITS_IN-1:0] mant;
    logic signed [FULL_W-1:0]    full;
    logic [SH_W-1:0]             shamt;
    logic [N_BITS_OUT:0]         sat_res;

    // Returns {saturated_flag, clamped_word}.
    function automatic logic [N_BITS_OUT:0] saturate(input logic signed [FULL_W-1:0] val);
        logic signed [CMP_W-1:0] wide;
        wide = CMP_W'(val);
        if (wide > OUT_MAX)
            return {1'b1, 1'b0, {(N_BITS_OUT-1){1'b1}}};
        else if (wide < OUT_MIN)
            return {1'b1, 1'b1, {(N_BITS_OUT-1){1'b0}}};
        else
            return {1'b0, wide[N_BITS_OUT-1:0]};
    endfunction

    assign mant    = s_data;
    assign shamt   = SH_W'(blk_exp) + SH_W'(DELTA);
    assign full    = FULL_W'(mant) <<< shamt;
    assign sat_res = saturate(full);

    assign s_ready = (state == HDR) || !m_valid || m_ready;
    assign accept  = s_valid && s_ready;

    always_comb begin
        state_nxt   = state;
        blk_exp_nxt = blk_exp;
        cnt_nxt     = cnt;
        err_nxt     = 1'b0;
        load        = 1'b0;
        if (accept) begin
            if (s_hdr) begin
                // A header in DATA is a resync: the partial block is abandoned.
                err_nxt     = (state == DATA);
                blk_exp_nxt = s_data[EXP_BITS-1:0];
                cnt_nxt     = '0;
                state_nxt   = DATA;
            end else if (state == HDR) begin
                err_nxt = 1'b1;
            end else begin
                load = 1'b1;
                if (cnt == LAST_CNT) begin
                    cnt_nxt   = '0;
                    state_nxt = HDR;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
        end
    end

    // Output register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= HDR;
            blk_exp <= '0;
            cnt     <= '0;
            err     <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
            m_sat   <= 1'b0;
        end else begin
            state   <= state_nxt;
            blk_exp <= blk_exp_nxt;
            cnt     <= cnt_nxt;
            err     <= err_nxt;
            if (load) begin
                m_valid <= 1'b1;
                m_data  <= sat_res[N_BITS_OUT-1:0];
                m_sat   <= sat_res[N_BITS_OUT];
                m_last  <= (cnt == LAST_CNT);
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/bfp_expand.md
# bfp_expand

Block-floating-point expander: accepts a stream of narrow signed mantissas, each block of BLOCK_LEN mantissas preceded by one shared exponent header. It emits each sample as a wider signed fixed-point word equal to mantissa × 2^exponent, re-aligned to the output binary point, with saturation. It is the receive-side inverse of the datapath's precision-reducing width conversion and sits at the input of processing that needs full-scale fixed-point samples.

## Interface
- N_BITS_IN, 4, input mantissa width (signed two's complement)
- BIN_PT_IN, 3, input binary point position
- N_BITS_OUT, 8, output word width (signed two's complement)
- BIN_PT_OUT, 7, output binary point position; BIN_PT_OUT >= BIN_PT_IN is required and enforced by an elaboration-time check
- BLOCK_LEN, 16, data beats per block; must be >= 1
- EXP_BITS, 3, exponent field width (unsigned); EXP_BITS <= N_BITS_IN
- clk  input  1  sole clock; all logic rising-edge
- rst_n  input  1  asynchronous active-low reset
- s_data  input  N_BITS_IN  mantissa, or exponent in bits [EXP_BITS-1:0] when s_hdr=1
- s_hdr  input  1  marks the current beat as an exponent header
- s_valid  input  1  input beat valid
- s_ready  output  1  input beat accepted when s_valid && s_ready
- m_data  output  N_BITS_OUT  expanded sample
- m_valid  output  1  output valid
- m_ready  input  1  downstream ready
- m_last  output  1  set on the final sample of a block
- m_sat  output  1  set when the current m_data was saturated
- err  output  1  one-cycle pulse on a framing error

## Operation
- States: HDR (awaiting exponent) and DATA (counting BLOCK_LEN mantissas). Reset state is HDR.
- HDR, accepted beat with s_hdr=1: latch exp = s_data[EXP_BITS-1:0], clear cnt, go to DATA. No output is produced.
- HDR, accepted beat with s_hdr=0: drop the beat, pulse err, stay in HDR.
- DATA, accepted beat with s_hdr=0: compute the sample, load the output register, cnt++.
  - m_last = (cnt == BLOCK_LEN-1).
  - On that beat, return to HDR.
- DATA, accepted beat with s_hdr=1: resync. Pulse err, latch the new exp, clear cnt, stay in DATA. No output is produced. A truncated block therefore never asserts m_last.
- Arithmetic: shift = exp + BIN_PT_OUT - BIN_PT_IN.
  - full = sign_extend(s_data) << shift, computed at width N_BITS_IN + 2^EXP_BITS - 1 + BIN_PT_OUT - BIN_PT_IN.
  - If full > 2^(N_BITS_OUT-1)-1, output the max positive value and set m_sat.
  - If full < -2^(N_BITS_OUT-1), output the max negative value and set m_sat.
  - Otherwise output the low N_BITS_OUT bits of full, with m_sat=0.
- Reset (any time, including mid-block or while m_valid is stalled):
  - m_valid=0, m_data=0, m_last=0, m_sat=0, err=0.
  - exp=0, cnt=0, state=HDR.
  - Any pending output is discarded.

## Timing
- s_ready: 1 in HDR; in DATA, s_ready = !m_valid || m_ready (combinational from m_ready). There is no combinational path from s_* to m_*.
- Latency: one cycle from data-beat acceptance to m_valid, with m_data/m_last/m_sat registered together.
- Throughput: one sample per cycle with m_ready held high. Each header costs one bubble cycle.
- Output hold: m_data, m_last and m_sat are stable while m_valid && !m_ready.
- m_valid drops the cycle after the handshake unless a new beat was accepted in the same cycle.
- Header acceptance while the output is stalled is allowed. It does not disturb the held output.
- err is registered: it pulses in the cycle after the offending beat is accepted and is never asserted for more than one cycle per event.
- cnt wraps only through the DATA→HDR transition; no other wrap exists.

## Test plan
- Basic block, defaults: header exp=0, then mantissas 3, -8, 7 with m_ready=1 → m_data 48, -128, 112, one cycle after each acceptance; m_sat=0; m_last only on the 16th sample.
- Scaling and saturation: exp=1 with mantissas 3, -8; exp=2 with mantissa 3 → 96 (m_sat=0), -128 (m_sat=1), 127 (m_sat=1).
- Backpressure: hold m_ready=0 for 5 cycles mid-block → s_ready=0 in DATA, m_data held constant; on release, no sample is lost or duplicated and 16 samples arrive with a single m_last.
- Framing errors:
  - A data beat in HDR → dropped, err pulses once, no m_valid.
  - A header after 5 data beats → err pulses once; the new block requires 16 more samples before m_last.
- Async reset mid-block with m_valid=1 → all outputs 0 immediately. After release, a data beat without a header is dropped with err, and a header plus 16 beats produces a normal block.
